// File: rtl/xor_swap_engine_pkg.sv
// Shared types and constants for the XOR swap engine.
package xor_swap_engine_pkg;

  // Completed-swap counter width; the counter wraps naturally at 2**COUNT_W.
  localparam int COUNT_W = 8;

  // Swap sequencer states: IDLE accepts host writes or a swap request,
  // X2 and X3 are the second and third XOR steps of an in-flight swap.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_X2   = 2'd1,
    ST_X3   = 2'd2
  } swap_state_t;

endpackage

// File: rtl/xor_swap_if.sv
// Host-side bus of the XOR swap engine: write port, swap handshake, status.
interface xor_swap_if
  import xor_swap_engine_pkg::*;
#(
  parameter int WIDTH = 5
);
  logic               wr_en;
  logic               wr_sel;
  logic [WIDTH-1:0]   wr_data;
  logic               swap_req;
  logic               swap_ack;
  logic               busy;
  logic               wr_err;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic [COUNT_W-1:0] swap_count;

  // Host side: drives writes and swap requests, observes the registers.
  modport master (
    output wr_en, wr_sel, wr_data, swap_req,
    input  swap_ack, busy, wr_err, a, b, swap_count
  );

  // Engine side.
  modport slave (
    input  wr_en, wr_sel, wr_data, swap_req,
    output swap_ack, busy, wr_err, a, b, swap_count
  );
endinterface

// File: rtl/xor_swap_engine.sv
// Two host-writable registers that swap in place with three XOR steps
// (no temporary storage). Intermediate XOR values are visible on a/b;
// consumers qualify on swap_ack or !busy.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | accept writes; swap_req without wr_en does a <= a^b
//   ST_X2   | b <= b^a; writes rejected with wr_err
//   ST_X3   | a <= a^b, ack and count; writes rejected with wr_err
module xor_swap_engine
  import xor_swap_engine_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int RST_A = 10,
  parameter int RST_B = 20
) (
  input  logic       clk,
  input  logic       rst,
  xor_swap_if.slave  bus
);

  logic [WIDTH-1:0]   reg_a;
  logic [WIDTH-1:0]   reg_b;
  logic [COUNT_W-1:0] count_q;
  logic               ack_q;
  logic               err_q;
  logic               busy_c;
  swap_state_t        state;
  swap_state_t        state_nxt;

  // Next-state: a write in IDLE takes priority, so a coincident request is dropped.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (bus.swap_req && !bus.wr_en) state_nxt = ST_X2;
      ST_X2:   state_nxt = ST_X3;
      ST_X3:   state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Busy is decoded straight from the state register.
  always_comb begin
    busy_c = (state != ST_IDLE);
  end

  // State, data registers, counter and the one-cycle pulses share one register process.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      reg_a   <= WIDTH'(RST_A);
      reg_b   <= WIDTH'(RST_B);
      count_q <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state <= state_nxt;
      ack_q <= 1'b0;
      err_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.wr_en) begin
            if (bus.wr_sel) reg_b <= bus.wr_data;
            else            reg_a <= bus.wr_data;
          end else if (bus.swap_req) begin
            reg_a <= reg_a ^ reg_b;
          end
        end
        ST_X2: begin
          reg_b <= reg_b ^ reg_a;
          if (bus.wr_en) err_q <= 1'b1;
        end
        ST_X3: begin
          reg_a   <= reg_a ^ reg_b;
          ack_q   <= 1'b1;
          count_q <= count_q + 1'b1;
          if (bus.wr_en) err_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign bus.a          = reg_a;
  assign bus.b          = reg_b;
  assign bus.swap_count = count_q;
  assign bus.swap_ack   = ack_q;
  assign bus.wr_err     = err_q;
  assign bus.busy       = busy_c;

endmodule

// File: tb/tb_xor_swap_engine.sv
// Self-checking bench for xor_swap_engine: directed stimulus with a
// scoreboard of expected post-swap register values checked at each ack.
module tb_xor_swap_engine;
  import xor_swap_engine_pkg::*;

  typedef struct packed {
    logic [4:0] a;
    logic [4:0] b;
    logic [7:0] cnt;
  } exp_t;

  logic clk;
  logic rst;
  xor_swap_if #(.WIDTH(5)) bus ();

  xor_swap_engine #(.WIDTH(5), .RST_A(10), .RST_B(20)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];
  logic [4:0] m_a;
  logic [4:0] m_b;
  logic [7:0] m_cnt;
  int   err_pulses = 0;
  int   ack_pulses = 0;
  bit   watch_b3 = 0;
  bit   saw_b3 = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // Reference swap: plain exchange, independent of the XOR sequence.
  task automatic push_swap();
    logic [4:0] t;
    exp_t e;
    t     = m_a;
    m_a   = m_b;
    m_b   = t;
    m_cnt = m_cnt + 8'd1;
    e.a   = m_a;
    e.b   = m_b;
    e.cnt = m_cnt;
    sb_q.push_back(e);
  endtask

  task automatic do_write(input logic sel, input logic [4:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_sel  = sel;
    bus.wr_data = d;
    tick();
    bus.wr_en = 1'b0;
    if (sel) m_b = d; else m_a = d;
    chk("wr_a", bus.a, m_a);
    chk("wr_b", bus.b, m_b);
  endtask

  task automatic do_swap();
    push_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    chk("sw_busy_x2", bus.busy, 1);
    tick();
    chk("sw_busy_x3", bus.busy, 1);
    tick();
    chk("sw_ack", bus.swap_ack, 1);
    tick();
    chk("sw_ack_low", bus.swap_ack, 0);
    chk("sw_idle", bus.busy, 0);
  endtask

  // Scoreboard/monitor: every ack must match the oldest pending expectation.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus.wr_err) err_pulses++;
      if (watch_b3 && bus.b == 5'd3) saw_b3 = 1;
      if (bus.swap_ack) begin
        ack_pulses++;
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", 1, 0);
        end else begin
          e = sb_q.pop_front();
          chk("sb_a", bus.a, e.a);
          chk("sb_b", bus.b, e.b);
          chk("sb_cnt", bus.swap_count, e.cnt);
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.wr_en = 1'b0;
    bus.wr_sel = 1'b0;
    bus.wr_data = '0;
    bus.swap_req = 1'b0;
    m_a = 5'd10;
    m_b = 5'd20;
    m_cnt = 8'd0;

    // Reset acts before any clock edge.
    #2;
    chk("rst_a", bus.a, 10);
    chk("rst_b", bus.b, 20);
    chk("rst_busy", bus.busy, 0);
    chk("rst_ack", bus.swap_ack, 0);
    chk("rst_err", bus.wr_err, 0);
    chk("rst_cnt", bus.swap_count, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("idle_a", bus.a, 10);
    chk("idle_b", bus.b, 20);
    chk("idle_busy", bus.busy, 0);
    chk("idle_cnt", bus.swap_count, 0);

    // Swap from reset values with visible intermediates.
    push_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    chk("t1_x2_a", bus.a, 30);
    chk("t1_x2_b", bus.b, 20);
    chk("t1_x2_busy", bus.busy, 1);
    chk("t1_x2_ack", bus.swap_ack, 0);
    tick();
    chk("t1_x3_a", bus.a, 30);
    chk("t1_x3_b", bus.b, 10);
    chk("t1_x3_ack", bus.swap_ack, 0);
    tick();
    chk("t1_ack", bus.swap_ack, 1);
    chk("t1_ack_a", bus.a, 20);
    chk("t1_ack_b", bus.b, 10);
    chk("t1_cnt", bus.swap_count, 1);
    chk("t1_ack_busy", bus.busy, 0);
    tick();
    chk("t1_ack_low", bus.swap_ack, 0);

    // Equal operands, then zero operand.
    do_write(1'b0, 5'd7);
    do_write(1'b1, 5'd7);
    do_swap();
    chk("eq_a", bus.a, 7);
    chk("eq_b", bus.b, 7);
    do_write(1'b0, 5'd0);
    do_write(1'b1, 5'd31);
    do_swap();
    chk("zero_a", bus.a, 31);
    chk("zero_b", bus.b, 0);
    chk("zero_cnt", bus.swap_count, 3);

    // Write during X2 is rejected with a single wr_err pulse.
    do_write(1'b0, 5'd10);
    do_write(1'b1, 5'd20);
    watch_b3 = 1;
    push_swap();
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_sel = 1'b1;
    bus.wr_data = 5'd3;
    tick();
    bus.wr_en = 1'b0;
    chk("werr_pulse", bus.wr_err, 1);
    tick();
    chk("werr_low", bus.wr_err, 0);
    chk("werr_ack", bus.swap_ack, 1);
    chk("werr_a", bus.a, 20);
    chk("werr_b", bus.b, 10);
    tick();
    watch_b3 = 0;
    chk("werr_b_never_3", saw_b3, 0);

    // Write and swap request together: write wins, no swap.
    do_write(1'b1, 5'd20);
    bus.swap_req = 1'b1;
    do_write(1'b0, 5'd5);
    bus.swap_req = 1'b0;
    chk("wins_busy", bus.busy, 0);
    chk("wins_a", bus.a, 5);
    chk("wins_b", bus.b, 20);
    tick();
    chk("wins_busy2", bus.busy, 0);
    chk("wins_ack", bus.swap_ack, 0);

    // Request held across ack starts a second swap right away.
    push_swap();
    push_swap();
    bus.swap_req = 1'b1;
    tick();
    tick();
    tick();
    chk("hold_ack1", bus.swap_ack, 1);
    tick();
    bus.swap_req = 1'b0;
    chk("hold_busy2", bus.busy, 1);
    tick();
    tick();
    chk("hold_ack2", bus.swap_ack, 1);
    chk("hold_a", bus.a, 5);
    chk("hold_b", bus.b, 20);
    tick();
    chk("hold_idle", bus.busy, 0);

    // Reset during X3 aborts without ack.
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick();
    chk("abort_in_x3", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("abort_a", bus.a, 10);
    chk("abort_b", bus.b, 20);
    chk("abort_busy", bus.busy, 0);
    chk("abort_ack", bus.swap_ack, 0);
    chk("abort_cnt", bus.swap_count, 0);
    tick();
    rst = 1'b0;
    m_a = 5'd10;
    m_b = 5'd20;
    m_cnt = 8'd0;
    tick();
    chk("abort_no_ack", bus.swap_ack, 0);
    chk("abort_idle", bus.busy, 0);

    // Counter wrap after 256 completed swaps.
    for (int i = 0; i < 256; i++) begin
      do_swap();
      if (i == 254) chk("cnt_255", bus.swap_count, 255);
    end
    chk("cnt_wrap", bus.swap_count, 0);
    chk("wrap_a", bus.a, 10);
    chk("wrap_b", bus.b, 20);

    tick();
    chk("sb_empty", sb_q.size(), 0);
    chk("err_pulses", err_pulses, 1);
    chk("ack_pulses", ack_pulses, 262);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/xor_swap_engine.md
XOR_SWAP_ENGINE -- requirements
Module: xor_swap_engine

Interface
REQ-001 Parameter WIDTH, default 5, data width of both registers.
REQ-002 Parameter RST_A, default 10, reset value of register A.
REQ-003 Parameter RST_B, default 20, reset value of register B.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 wr_en  input  1  host write strobe, one write per asserted cycle.
REQ-007 wr_sel  input  1  write target: 0 = A, 1 = B.
REQ-008 wr_data  input  WIDTH  write data.
REQ-009 swap_req  input  1  swap request, sampled only in IDLE.
REQ-010 swap_ack  output  1  one-cycle pulse: swap complete, a/b hold swapped values.
REQ-011 busy  output  1  high while a swap is in progress.
REQ-012 wr_err  output  1  one-cycle pulse: a write was rejected because busy.
REQ-013 a  output  WIDTH  register A contents (registered).
REQ-014 b  output  WIDTH  register B contents (registered).
REQ-015 swap_count  output  8  count of completed swaps; wraps 255 -> 0.

Function
REQ-016 Swap SHALL use no temporary register: three XOR steps on A and B only.
REQ-017 FSM states: IDLE, X2, X3; busy = (state != IDLE), combinational from state.
REQ-018 IDLE, swap_req=1, wr_en=0, edge: a <= a^b; next state X2.
REQ-019 X2, edge: b <= b^a; next state X3.
REQ-020 X3, edge: a <= a^b; swap_ack <= 1; swap_count <= swap_count+1; next state IDLE.
REQ-021 Latency: swap_ack is high in the 3rd cycle after the sampling edge, the same cycle a/b first show swapped values.
REQ-022 Intermediate a/b values during X2/X3 SHALL be visible on outputs; consumers qualify on swap_ack or !busy.
REQ-023 IDLE, wr_en=1: selected register <= wr_data on the edge; the other register is unchanged.
REQ-024 IDLE, wr_en=1 and swap_req=1 in the same cycle: write wins; swap is not started and is not queued.
REQ-025 wr_en=1 while busy: write is dropped; wr_err pulses high for one cycle; a/b follow the swap sequence.
REQ-026 swap_req while busy is ignored and not queued; req held high after ack starts a new swap on the next IDLE edge.
REQ-027 a == b: the sequence runs normally; values are unchanged; ack and count still update.
REQ-028 a or b == 0: the swap SHALL complete correctly.
REQ-029 swap_ack and wr_err are low in every cycle not specified above.

Reset
REQ-030 When rst is asserted, a = RST_A, b = RST_B, state = IDLE, swap_ack = 0, wr_err = 0, swap_count = 0, regardless of clk.
REQ-031 rst mid-swap (X2/X3) SHALL abort the sequence; no ack is issued and count is not incremented.
REQ-032 First swap_req is sampled on the first rising edge after rst deasserts.

Structure
REQ-033 A shared package SHALL hold the FSM state enum (IDLE, X2, X3) and the swap_count width constant (8).
REQ-034 Single flat module; no sub-module; one sequential process for a, b, state, and pulses.

Verification
REQ-035 Reset, then 1 cycle idle -> a=10, b=20, busy=0, swap_count=0.
REQ-036 swap_req pulse from reset values -> a/b traverse (30,20), (30,10), (20,10); swap_ack high with a=20, b=10; count=1.
REQ-037 Write A=7, B=7, then swap -> a=b=7 at ack; count increments; then write A=0, B=31 and swap -> a=31, b=0.
REQ-038 wr_en (sel=1, data=3) during X2 -> wr_err pulses once; final a=20, b=10; b never equals 3.
REQ-039 wr_en (A=5) with swap_req in the same IDLE cycle -> a=5, b=20, busy stays 0, no ack.
REQ-040 rst asserted during X3 -> a=10, b=20, IDLE, no ack; 256 completed swaps -> swap_count wraps to 0.
